// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory port controller: FSM state
// encoding and the NOP word returned on bad fetches.
package imem_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_CLEAR = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_RUN   = 2'd2;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage : imem_ctrl_pkg

// File: rtl/imem_port_ctrl.sv
// Arbitrates the single-port instruction array between the boot loader and
// CPU fetch. Optional build macro IMEM_CLEAR_EN zero-fills the array after reset.
module imem_port_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  input  logic              ld_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              run
);

`ifdef IMEM_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_LOAD;
`endif

  state_t state_q, state_d;
  logic   fetch_bad;

  // Misaligned or beyond the array depth.
  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:ADDR_W+2] != '0);

`ifdef IMEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_cnt <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end
`endif

  // Combinational outputs are gated by reset so every output reads 0 while
  // reset is held, regardless of the request inputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    state_d     = state_q;
    ld_ack      = 1'b0;
    fetch_ready = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (reset) begin
      case (state_q)
        ST_CLEAR: begin
`ifdef IMEM_CLEAR_EN
          mem_en   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = clr_cnt;
          if (clr_cnt == {ADDR_W{1'b1}}) state_d = ST_LOAD;
`else
          state_d = ST_LOAD;
`endif
        end
        ST_LOAD: begin
          if (ld_req) begin
            ld_ack    = 1'b1;
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_data;
          end
          if (ld_done) state_d = ST_RUN;
        end
        ST_RUN: begin
          // Loader wins; the fetch simply retries next cycle.
          if (ld_req) begin
            ld_ack    = 1'b1;
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_data;
          end else if (fetch_req) begin
            fetch_ready = 1'b1;
            if (!fetch_bad) begin
              mem_en   = 1'b1;
              mem_addr = fetch_addr[ADDR_W+1:2];
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RESET_STATE;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the
      // same pre-edge values.
      state_q     <= state_d;
      fetch_valid <= fetch_ready;
      fetch_err   <= fetch_ready & fetch_bad;
    end
  end

  // The array's synchronous read lands in the cycle fetch_valid is high.
  assign fetch_data = (fetch_valid && !fetch_err) ? mem_rdata : DATA_W'(NOP_WORD);
  assign run        = (state_q == ST_RUN);

endmodule : imem_port_ctrl

// File: tb/tb_imem_port_ctrl.sv
// Directed bench for imem_port_ctrl: expected fetch responses go into a
// scoreboard queue that an independent monitor drains on fetch_valid.
`timescale 1ns/100ps
module tb_imem_port_ctrl;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ack;
  logic              ld_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              run;

  int checks   = 0;
  int failures = 0;

  logic [32:0] sb_q[$];  // {err, data}

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always #5 clk = ~clk;

  imem_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .fetch_err  (fetch_err),
    .ld_req     (ld_req),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_ack     (ld_ack),
    .ld_done    (ld_done),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .run        (run)
  );

  // Synchronous-read, single-port array model.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every fetch_valid pulse must match the oldest expected response.
  always @(posedge clk) begin
    #1;
    if (reset && fetch_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 64'(fetch_valid), 64'd0);
      end else begin
        logic [32:0] exp;
        exp = sb_q.pop_front();
        check("fetch_err", 64'(fetch_err), 64'(exp[32]));
        check("fetch_data", 64'(fetch_data), 64'(exp[31:0]));
      end
    end
  end

  // One cycle of stimulus: drive at negedge, check combinational outputs just
  // before the edge, and confirm the response arrived one cycle later.
  task automatic step(input logic lr, input logic [ADDR_W-1:0] la, input logic [31:0] ldat,
                      input logic done, input logic fr, input logic [31:0] fa,
                      input logic exp_ack, input logic exp_ready, input logic exp_men,
                      input logic exp_run, input logic exp_err, input logic [31:0] exp_data);
    @(negedge clk);
    ld_req = lr; ld_addr = la; ld_data = ldat; ld_done = done;
    fetch_req = fr; fetch_addr = fa;
    #3;
    check("ld_ack", 64'(ld_ack), 64'(exp_ack));
    check("fetch_ready", 64'(fetch_ready), 64'(exp_ready));
    check("mem_en", 64'(mem_en), 64'(exp_men));
    check("mem_we", 64'(mem_we), 64'(exp_ack));
    check("run", 64'(run), 64'(exp_run));
    if (exp_ack) check("mem_wr_addr", 64'({mem_addr, mem_wdata}), 64'({la, ldat}));
    if (exp_men && !exp_ack) check("mem_rd_addr", 64'(mem_addr), 64'(fa[ADDR_W+1:2]));
    if (exp_ready) sb_q.push_back({exp_err, exp_data});
    @(posedge clk);
    #2;
    if (exp_ready) check("latency", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({fetch_ready, fetch_valid, fetch_err, ld_ack, mem_en, mem_we, run}), 64'd0);
    check({name, "_buses"}, 64'({fetch_data, mem_addr, mem_wdata}), 64'd0);
  endtask

  // Clear sweep checks, entered right at the negedge where reset releases.
  task automatic sweep();
`ifdef IMEM_CLEAR_EN
    ld_req = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      #3;
      check("clear_word", 64'({mem_en, mem_we, mem_addr, mem_wdata, ld_ack, fetch_ready}),
            64'({1'b1, 1'b1, ADDR_W'(i), 32'h0, 1'b0, 1'b0}));
      @(negedge clk);
    end
    ld_req = 1'b0;
`endif
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 32'hFFFF_0000 | 32'(i);
    reset = 1'b0;
    ld_req = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h0;

    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    reset = 1'b1;
    sweep();

    // Load, with a fetch held pending from reset.
    step(1, 6'd0, 32'h2008_0020, 0, 1, 32'h0, 1, 0, 1, 0, 0, 32'h0);
    step(1, 6'd1, 32'h2009_0037, 0, 1, 32'h0, 1, 0, 1, 0, 0, 32'h0);
    step(0, 6'd0, 32'h0,         1, 1, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    // Back-to-back fetches.
    step(0, 6'd0, 32'h0, 0, 1, 32'h0, 0, 1, 1, 1, 0, 32'h2008_0020);
    step(0, 6'd0, 32'h0, 0, 1, 32'h4, 0, 1, 1, 1, 0, 32'h2009_0037);
    // Loader beats fetch, then fetch reads the freshly written word.
    step(1, 6'd2, 32'hAC09_0000, 0, 1, 32'h8, 1, 0, 1, 1, 0, 32'h0);
    step(0, 6'd0, 32'h0,         0, 1, 32'h8, 0, 1, 1, 1, 0, 32'hAC09_0000);
    // Bad addresses: misaligned, then out of range.
    step(0, 6'd0, 32'h0, 0, 1, 32'h6,   0, 1, 0, 1, 1, 32'h0);
    step(0, 6'd0, 32'h0, 0, 1, 32'h100, 0, 1, 0, 1, 1, 32'h0);
    // ld_done ignored in RUN; idle cycle lets fetch_valid fall.
    step(0, 6'd0, 32'h0, 1, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
    step(0, 6'd0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
    #1;
    check("valid_falls", 64'(fetch_valid), 64'd0);

    // Reset lands between acceptance and the response edge.
    @(negedge clk);
    ld_done = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h4;
    #3;
    check("pre_reset_ready", 64'(fetch_ready), 64'd1);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #2;
    check_all_zero("mid_fetch_reset");
    @(negedge clk);
    reset = 1'b1;
    sweep();
    step(0, 6'd0, 32'h0, 0, 1, 32'h4, 0, 0, 0, 0, 0, 32'h0);
    step(0, 6'd0, 32'h0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
`ifdef IMEM_CLEAR_EN
    step(0, 6'd0, 32'h0, 0, 1, 32'h10, 0, 1, 1, 1, 0, 32'h0);
`else
    step(0, 6'd0, 32'h0, 0, 1, 32'h10, 0, 1, 1, 1, 0, 32'hFFFF_0004);
`endif
    step(0, 6'd0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_imem_port_ctrl
